// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and framing constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DATA_W            = 8;
    localparam int BAUD_DIV_9600_50M = 5208;
    localparam int FRAME_BITS_8N1    = 10;
    localparam int FRAME_BITS_8E1    = 11;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: enable-gated bit-period counter with sync clear and end-of-period ticks
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_9600_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic tick_early
);
    localparam int CW = $clog2(BAUD_DIV);
    logic [CW-1:0] cnt;
    assign tick       = en && cnt == CW'(BAUD_DIV - 1);
    assign tick_early = en && cnt == CW'(BAUD_DIV - 2);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready byte input and registered outputs
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_9600_50M
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy
);
    state_t state, state_nx;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic txd_d, tick, tick_early, accept, bit_end;

    assign accept  = tx_valid && tx_ready;
    assign bit_end = state == DATA && tick;

`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic parity;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) parity <= 1'b0;
        else if (accept) parity <= ^tx_data;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (busy),
        .clr       (!busy),
        .tick      (tick),
        .tick_early(tick_early)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            txd      <= txd_d;
            tx_ready <= state_nx == IDLE;
            busy     <= state_nx != IDLE;
        end

    // STOP hands over one cycle early; that IDLE cycle completes the stop bit,
    // so a byte already waiting is accepted with no gap after the full stop bit.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? START : IDLE;
            START:   state_nx = tick ? DATA : START;
            DATA:    state_nx = (tick && bit_cnt == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
            PARITY:  state_nx = tick ? STOP : PARITY;
`endif
            STOP:    state_nx = tick_early ? IDLE : STOP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        shift_d   = accept ? tx_data : bit_end ? shift >> 1 : shift;
        bit_cnt_d = bit_end ? bit_cnt + 3'd1 : bit_cnt;
`ifdef UART_TX_PARITY_EN
        txd_d = state_nx == START ? 1'b0 : state_nx == DATA ? shift_d[0] :
                state_nx == PARITY ? parity : 1'b1;
`else
        txd_d = state_nx == START ? 1'b0 : state_nx == DATA ? shift_d[0] : 1'b1;
`endif
    end
endmodule
